change_dispenser: RTL

- Coin-return engine on the output side of the vending path.
- Takes the 3-bit change code produced by the vending FSM, expands it into individual coins and drives the coin hopper one coin at a time over a req/ack handshake.
- Detects hopper jams by timeout and reports completion back to the vending logic.

---
 rtl/change_dispenser.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// change_dispenser: coin-return engine on the output side of the vending path.
// Expands a 3-bit change code into individual coins and drives the hopper one
// coin at a time over a req/ack handshake. Dispense order is quarter, then dimes,
// then nickel. A request that is not acknowledged within ACK_TIMEOUT cycles
// parks the engine in a jam state until the operator clears it.
//
// Parameters:
//   ACK_TIMEOUT  cycles coin_req may stay high without hopper_ack (>= 2)
//   GAP_CYCLES   minimum cycles between a coin's ack and the next coin_req (>= 1)
//   TOTAL_W      width of total_cents (only with CHANGE_TOTAL_EN)
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   change_valid  one-cycle strobe qualifying change
//   change        000 none, 001 N, 010 D, 011 N+D, 100 D+D, 101 Q, 110/111 invalid
//   hopper_ack    hopper released the requested coin (level)
//   clear_jam     operator clear of the jam condition
//   coin_req      one-hot {quarter, dime, nickel} request, registered
//   busy          high whenever the engine is not idle
//   done          one-cycle pulse when a change request completes
//   jam           high while jammed
//   overrun       one-cycle pulse: strobe arrived while busy and was dropped
//   bad_code      one-cycle pulse: invalid code received while idle
//   total_cents   saturating sum of acked coin values (CHANGE_TOTAL_EN only)
//
// Build option: define CHANGE_TOTAL_EN to add the total_cents accumulator.
module change_dispenser #(
  parameter int unsigned ACK_TIMEOUT = 1000,
  parameter int unsigned GAP_CYCLES  = 4
`ifdef CHANGE_TOTAL_EN
  ,
  parameter int unsigned TOTAL_W     = 16
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       change_valid,
  input  logic [2:0] change,
  input  logic       hopper_ack,
  input  logic       clear_jam,
  output logic [2:0] coin_req,
  output logic       busy,
  output logic       done,
  output logic       jam,
  output logic       overrun,
  output logic       bad_code
`ifdef CHANGE_TOTAL_EN
  ,
  output logic [TOTAL_W-1:0] total_cents
`endif
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] GAP  = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] JAM  = 3'd4;

  localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic             q_cnt_q, q_cnt_d;
  logic [1:0]       d_cnt_q, d_cnt_d;
  logic             n_cnt_q, n_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [2:0]       coin_sel;
  logic             any_left;

  always_comb begin
    state_d = state_q;
    q_cnt_d = q_cnt_q;
    d_cnt_d = d_cnt_q;
    n_cnt_d = n_cnt_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        gap_d = '0;
        if (change_valid) begin
          case (change)
            3'b000:  state_d = DONE;
            3'b001:  begin n_cnt_d = 1'b1;                   state_d = REQ; end
            3'b010:  begin d_cnt_d = 2'd1;                   state_d = REQ; end
            3'b011:  begin n_cnt_d = 1'b1; d_cnt_d = 2'd1;   state_d = REQ; end
            3'b100:  begin d_cnt_d = 2'd2;                   state_d = REQ; end
            3'b101:  begin q_cnt_d = 1'b1;                   state_d = REQ; end
            default: ;
          endcase
        end
      end
      REQ: begin
        if (hopper_ack) begin
          // coin_req holds the coin being paid, so it picks the counter to drop
          if (coin_req[2])      q_cnt_d = 1'b0;
          else if (coin_req[1]) d_cnt_d = d_cnt_q - 2'd1;
          else if (coin_req[0]) n_cnt_d = 1'b0;
          tmo_d   = '0;
          gap_d   = '0;
          state_d = GAP;
        end else if (tmo_q == TMO_LAST) begin
          tmo_d   = '0;
          state_d = JAM;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      GAP: begin
        // gap_q saturates at GAP_LAST, meaning GAP_CYCLES cycles have elapsed
        if (gap_q != GAP_LAST) gap_d = gap_q + 1'b1;
        if (gap_q == GAP_LAST && !hopper_ack) begin
          state_d = any_left ? REQ : DONE;
        end
      end
      DONE: state_d = IDLE;
      JAM: begin
        if (clear_jam) begin
          q_cnt_d = 1'b0;
          d_cnt_d = 2'd0;
          n_cnt_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign any_left = q_cnt_q | (d_cnt_q != 2'd0) | n_cnt_q;

  // Highest-priority coin still owed, taken from next-state counters so that
  // coin_req is valid in the first REQ cycle.
  always_comb begin
    if (q_cnt_d)                coin_sel = 3'b100;
    else if (d_cnt_d != 2'd0)   coin_sel = 3'b010;
    else if (n_cnt_d)           coin_sel = 3'b001;
    else                        coin_sel = 3'b000;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      q_cnt_q  <= 1'b0;
      d_cnt_q  <= 2'd0;
      n_cnt_q  <= 1'b0;
      tmo_q    <= '0;
      gap_q    <= '0;
      coin_req <= 3'b000;
      busy     <= 1'b0;
      done     <= 1'b0;
      jam      <= 1'b0;
      overrun  <= 1'b0;
      bad_code <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_cnt_q  <= q_cnt_d;
      d_cnt_q  <= d_cnt_d;
      n_cnt_q  <= n_cnt_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      coin_req <= (state_d == REQ) ? coin_sel : 3'b000;
      busy     <= (state_d != IDLE);
      done     <= (state_d == DONE);
      jam      <= (state_d == JAM);
      overrun  <= change_valid && (state_q != IDLE);
      bad_code <= change_valid && (state_q == IDLE) && (change[2:1] == 2'b11);
    end
  end

`ifdef CHANGE_TOTAL_EN
  logic [TOTAL_W-1:0] coin_val;
  logic [TOTAL_W:0]   total_sum;

  always_comb begin
    coin_val = '0;
    if (state_q == REQ && hopper_ack) begin
      if (coin_req[2])      coin_val = TOTAL_W'(25);
      else if (coin_req[1]) coin_val = TOTAL_W'(10);
      else if (coin_req[0]) coin_val = TOTAL_W'(5);
    end
    total_sum = {1'b0, total_cents} + {1'b0, coin_val};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      total_cents <= '0;
    end else if (total_sum[TOTAL_W]) begin
      total_cents <= '1;
    end else begin
      total_cents <= total_sum[TOTAL_W-1:0];
    end
  end
`endif

endmodule
